// File: rtl/cve2_pmp_csr_regs_pkg.sv
// Shared PMP types and CSR address constants for the cve2 PMP CSR block.
// Also provides the helper that packs a region's cfg into its pmpcfg byte.
package cve2_pkg;

  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [CSR_ADDR_W-1:0] CSR_PMPADDR0 = 12'h3B0;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSECCFG  = 12'h747;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSECCFGH = 12'h757;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  function automatic logic [7:0] pmp_cfg_byte(input pmp_cfg_t c);
    return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
  endfunction

endpackage

// File: rtl/cve2_pmp_csr_regs_if.sv
// CSR access port between the core's CSR file and the PMP CSR storage.
interface cve2_pmp_csr_regs_if;
  import cve2_pkg::*;

  logic                  we;
  logic [CSR_ADDR_W-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  hit;

  modport master (output we, addr, wdata, input rdata, hit);
  modport slave  (input we, addr, wdata, output rdata, hit);
endinterface

// File: rtl/cve2_pmp_entry_reg.sv
// One PMP region: cfg/addr flops, lock gating and WARL legalisation,
// plus the granularity-adjusted pmpaddr read-back value.
module cve2_pmp_entry_reg
  import cve2_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_we,
  input  pmp_cfg_t      cfg_wdata,
  input  logic          addr_we,
  input  logic [31:0]   addr_wdata,
  input  logic          next_lock,
  input  pmp_cfg_mode_e next_mode,
  input  logic          mml,
  input  logic          rlb,
  output pmp_cfg_t      cfg,
  output logic [31:0]   addr,
  output logic [31:0]   addr_rdata
);

  localparam int unsigned GM1       = (PMPGranularity > 0) ? PMPGranularity - 1 : 0;
  localparam logic [31:0] ZERO_MASK = 32'((64'd1 << PMPGranularity) - 64'd1);
  localparam logic [31:0] ONE_MASK  = 32'((64'd1 << GM1) - 64'd1);

  pmp_cfg_t cfg_legal;
  logic     mml_illegal;
  logic     cfg_blocked;
  logic     addr_blocked;

  always_comb begin
    cfg_legal = cfg_wdata;
    // NA4 cannot be represented once the grain exceeds 4 bytes
    if (PMPGranularity > 0 && cfg_wdata.mode == PMP_MODE_NA4) begin
      cfg_legal.mode = cfg.mode;
    end
    mml_illegal  = cfg_wdata.lock &&
                   ((cfg_wdata.write && !cfg_wdata.read) ||
                    (cfg_wdata.exec && !(cfg_wdata.read && cfg_wdata.write)));
    cfg_blocked  = (cfg.lock && !rlb) ||
                   (mml && !rlb && mml_illegal) ||
                   (!mml && cfg_wdata.write && !cfg_wdata.read);
    addr_blocked = !rlb && (cfg.lock || (next_lock && next_mode == PMP_MODE_TOR));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg  <= '0;
      addr <= '0;
    end else begin
      if (cfg_we && !cfg_blocked) cfg <= cfg_legal;
      if (addr_we && !addr_blocked) addr <= addr_wdata;
    end
  end

  always_comb begin
    addr_rdata = addr;
    if (PMPGranularity > 0) begin
      if (cfg.mode == PMP_MODE_NAPOT) begin
        addr_rdata = addr | ONE_MASK;
      end else if (cfg.mode == PMP_MODE_OFF || cfg.mode == PMP_MODE_TOR) begin
        addr_rdata = addr & ~ZERO_MASK;
      end
    end
  end

endmodule

// File: rtl/cve2_pmp_csr_regs.sv
// PMP CSR storage: address decode, read mux and mseccfg, with one
// cve2_pmp_entry_reg per implemented region feeding the PMP checker.
module cve2_pmp_csr_regs
  import cve2_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  cve2_pmp_csr_regs_if.slave           bus,
  output logic [PMPNumRegions*6-1:0]   csr_pmp_cfg_o,
  output logic [PMPNumRegions*34-1:0]  csr_pmp_addr_o,
  output pmp_mseccfg_t                 csr_pmp_mseccfg_o
);

  pmp_cfg_t     cfg        [PMPNumRegions];
  logic [31:0]  addr       [PMPNumRegions];
  logic [31:0]  addr_rdata [PMPNumRegions];
  pmp_mseccfg_t mseccfg;
  logic         any_lock;
  logic         mseccfg_we;

  for (genvar i = 0; i < PMPNumRegions; i++) begin : g_region
    logic          cfg_we;
    logic          addr_we;
    pmp_cfg_t      cfg_wdata;
    logic          next_lock;
    pmp_cfg_mode_e next_mode;

    assign cfg_we    = bus.we && (bus.addr == CSR_PMPCFG0 + 12'(i / 4));
    assign addr_we   = bus.we && (bus.addr == CSR_PMPADDR0 + 12'(i));
    assign cfg_wdata = pmp_cfg_t'({bus.wdata[8*(i%4)+7], bus.wdata[8*(i%4) +: 5]});

    if (i + 1 < PMPNumRegions) begin : g_next
      assign next_lock = cfg[i+1].lock;
      assign next_mode = cfg[i+1].mode;
    end else begin : g_last
      assign next_lock = 1'b0;
      assign next_mode = PMP_MODE_OFF;
    end

    cve2_pmp_entry_reg #(
      .PMPGranularity(PMPGranularity)
    ) u_entry (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .cfg_we     (cfg_we),
      .cfg_wdata  (cfg_wdata),
      .addr_we    (addr_we),
      .addr_wdata (bus.wdata),
      .next_lock  (next_lock),
      .next_mode  (next_mode),
      .mml        (mseccfg.mml),
      .rlb        (mseccfg.rlb),
      .cfg        (cfg[i]),
      .addr       (addr[i]),
      .addr_rdata (addr_rdata[i])
    );

    // Region 0 occupies the most significant slice
    assign csr_pmp_cfg_o[(PMPNumRegions-1-i)*6 +: 6]   = cfg[i];
    assign csr_pmp_addr_o[(PMPNumRegions-1-i)*34 +: 34] = {addr[i], 2'b00};
  end

  always_comb begin
    any_lock = 1'b0;
    for (int unsigned r = 0; r < PMPNumRegions; r++) begin
      any_lock = any_lock | cfg[r].lock;
    end
  end

  assign mseccfg_we = bus.we && (bus.addr == CSR_MSECCFG);

  // MML/MMWP are sticky; RLB only moves while unlocked or already set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mseccfg <= '0;
    end else if (mseccfg_we) begin
      mseccfg.mml  <= mseccfg.mml  | bus.wdata[0];
      mseccfg.mmwp <= mseccfg.mmwp | bus.wdata[1];
      if (mseccfg.rlb || !any_lock) mseccfg.rlb <= bus.wdata[2];
    end
  end

  assign csr_pmp_mseccfg_o = mseccfg;

  always_comb begin
    bus.rdata = '0;
    bus.hit   = 1'b0;
    if (bus.addr[11:2] == CSR_PMPCFG0[11:2]) begin
      bus.hit = 1'b1;
      for (int unsigned r = 0; r < PMPNumRegions; r++) begin
        if (bus.addr[1:0] == 2'(r / 4)) bus.rdata[8*(r%4) +: 8] = pmp_cfg_byte(cfg[r]);
      end
    end else if (bus.addr[11:4] == CSR_PMPADDR0[11:4]) begin
      bus.hit = 1'b1;
      for (int unsigned r = 0; r < PMPNumRegions; r++) begin
        if (bus.addr[3:0] == 4'(r)) bus.rdata = addr_rdata[r];
      end
    end else if (bus.addr == CSR_MSECCFG) begin
      bus.hit   = 1'b1;
      bus.rdata = {29'b0, mseccfg};
    end else if (bus.addr == CSR_MSECCFGH) begin
      bus.hit = 1'b1;
    end
  end

endmodule
